// File: rtl/oled_frame_scheduler.sv
// Streams a fixed OLED addressing preamble followed by a shadowed 1024-byte frame
// over a valid/ready byte handshake. Optional blink inversion: OLED_SCHED_BLINK_EN.
module oled_frame_scheduler #(
    parameter int REFRESH_CYCLES = 2500000,
    parameter int N_BYTES        = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             estado,
    input  logic [N_BYTES*8-1:0]   imagem,
    output logic [7:0]             byte_out,
    output logic                   byte_dc,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   frame_busy,
    output logic                   frame_done
);
    localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IDX_W = ($clog2(N_BYTES) < 3) ? 3 : $clog2(N_BYTES);
    localparam int SEL_W = $clog2(N_BYTES * 8);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CMD, S_DATA, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           estado_q;
    logic                 pending_q, pending_d;
    logic [N_BYTES*8-1:0] shadow_q, shadow_d;
    logic [7:0]           byte_out_q, byte_out_d;
    logic                 byte_dc_q, byte_dc_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 frame_busy_q, frame_busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 trigger, enter_latch, accept;
    logic [SEL_W-1:0]     sel;
    logic [7:0]           data_mask;
`ifdef OLED_SCHED_BLINK_EN
    logic                 blink_q, blink_d;
    logic [3:0]           est_lat_q, est_lat_d;
`endif

    always_comb begin
        trigger     = (estado != estado_q) || (cnt_q == CNT_W'(REFRESH_CYCLES - 1));
        enter_latch = (state_q == S_IDLE) && pending_q;
        accept      = byte_valid_q && byte_ready;

        // A trigger on the LATCH-entry edge wins over the clear, queueing one more frame.
        pending_d = trigger ? 1'b1 : (enter_latch ? 1'b0 : pending_q);

        // The entry cycle counts as the first cycle of the new refresh period.
        if (enter_latch)
            cnt_d = CNT_W'(1);
        else if (cnt_q == CNT_W'(REFRESH_CYCLES - 1))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
`ifdef OLED_SCHED_BLINK_EN
        blink_d   = blink_q;
        est_lat_d = est_lat_q;
`endif
        unique case (state_q)
            S_IDLE: if (pending_q) state_d = S_LATCH;
            S_LATCH: begin
                shadow_d = imagem;
                idx_d    = '0;
                state_d  = S_CMD;
`ifdef OLED_SCHED_BLINK_EN
                est_lat_d = estado_q;
`endif
            end
            S_CMD: if (accept) begin
                if (idx_q == IDX_W'(5)) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DATA: if (accept) begin
                if (idx_q == IDX_W'(N_BYTES - 1)) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef OLED_SCHED_BLINK_EN
                blink_d = ~blink_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

`ifdef OLED_SCHED_BLINK_EN
        data_mask = (est_lat_q == 4'd4 && blink_q) ? 8'hFF : 8'h00;
`else
        data_mask = 8'h00;
`endif
        sel = SEL_W'(idx_d) << 3;

        // Outputs are registered from the next state so they line up with it.
        byte_out_d   = 8'h00;
        byte_dc_d    = 1'b0;
        byte_valid_d = 1'b0;
        frame_busy_d = (state_d == S_LATCH) || (state_d == S_CMD) || (state_d == S_DATA);
        frame_done_d = (state_d == S_DONE);
        if (state_d == S_CMD) begin
            byte_valid_d = 1'b1;
            unique case (idx_d[2:0])
                3'd0:    byte_out_d = 8'h21;
                3'd1:    byte_out_d = 8'h00;
                3'd2:    byte_out_d = 8'h7F;
                3'd3:    byte_out_d = 8'h22;
                3'd4:    byte_out_d = 8'h00;
                3'd5:    byte_out_d = 8'h07;
                default: byte_out_d = 8'h00;
            endcase
        end else if (state_d == S_DATA) begin
            byte_valid_d = 1'b1;
            byte_dc_d    = 1'b1;
            byte_out_d   = shadow_q[sel +: 8] ^ data_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            estado_q     <= 4'd0;
            pending_q    <= 1'b1;
            shadow_q     <= '0;
            byte_out_q   <= 8'h00;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef OLED_SCHED_BLINK_EN
            blink_q      <= 1'b0;
            est_lat_q    <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            estado_q     <= estado;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            byte_out_q   <= byte_out_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
`ifdef OLED_SCHED_BLINK_EN
            blink_q      <= blink_d;
            est_lat_q    <= est_lat_d;
`endif
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_dc    = byte_dc_q;
    assign byte_valid = byte_valid_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Directed bench for oled_frame_scheduler: one DUT for stream/stall/trigger/abort
// scenarios and a second with a short refresh period for the periodic-refresh check.
module tb_oled_frame_scheduler;
    localparam int N    = 1024;
    localparam int RC_A = 60000;
    localparam int RC_B = 2000;
    localparam int FLEN = 6 + N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           rst_a = 1'b1, ready_a = 1'b1;
    logic [3:0]     est_a = 4'd0;
    logic [N*8-1:0] img_a = '0;
    logic [7:0]     a_byte;
    logic           a_dc, a_valid, a_busy, a_done;

    logic           rst_b = 1'b1, ready_b = 1'b1;
    logic [3:0]     est_b = 4'd0;
    logic [N*8-1:0] img_b = '0;
    logic [7:0]     b_byte;
    logic           b_dc, b_valid, b_busy, b_done;

    oled_frame_scheduler #(.REFRESH_CYCLES(RC_A), .N_BYTES(N)) dut_a (
        .clk(clk), .rst(rst_a), .estado(est_a), .imagem(img_a),
        .byte_out(a_byte), .byte_dc(a_dc), .byte_valid(a_valid), .byte_ready(ready_a),
        .frame_busy(a_busy), .frame_done(a_done)
    );

    oled_frame_scheduler #(.REFRESH_CYCLES(RC_B), .N_BYTES(N)) dut_b (
        .clk(clk), .rst(rst_b), .estado(est_b), .imagem(img_b),
        .byte_out(b_byte), .byte_dc(b_dc), .byte_valid(b_valid), .byte_ready(ready_b),
        .frame_busy(b_busy), .frame_done(b_done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Monitor for dut_a: accepted {dc, byte} log, frame_done count, timing marks, stall stability.
    logic [8:0] acc_q[$];
    int   done_cnt = 0, latch_cyc = 0, done_cyc = 0, stall_err = 0, stall_cnt = 0;
    logic prev_busy = 1'b0, prev_stall = 1'b0;
    logic [8:0] prev_out = '0;
    always @(negedge clk) begin
        if (a_valid && ready_a) acc_q.push_back({a_dc, a_byte});
        if (a_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (a_busy && !prev_busy) latch_cyc <= cyc;
        prev_busy <= a_busy;
        if (prev_stall && (({a_dc, a_byte} != prev_out) || !a_valid)) stall_err <= stall_err + 1;
        if (a_valid && !ready_a) stall_cnt <= stall_cnt + 1;
        prev_stall <= a_valid && !ready_a;
        prev_out   <= {a_dc, a_byte};
    end

    int b_start_q[$];
    always @(negedge clk) begin
        if (b_valid && ready_b && !b_dc && b_byte == 8'h21) b_start_q.push_back(cyc);
    end

    function automatic logic [8:0] exp_entry(input logic [N*8-1:0] im, input int k, input logic inv);
        logic [7:0] cmd [6];
        cmd = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        if (k < 6) return {1'b0, cmd[k]};
        return {1'b1, im[(k-6)*8 +: 8] ^ {8{inv}}};
    endfunction

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_size(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (acc_q.size() >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_rst_a();
        @(posedge clk); #1 rst_a = 1'b1;
        @(posedge clk); #1 rst_a = 1'b0;
    endtask

    task automatic test_reset();
        int base, bd, bad;
        bit ok;
        for (int i = 0; i < N; i++) img_a[i*8 +: 8] = 8'(i * 7 + 3);
        img_a[7:0]         = 8'hA5;
        img_a[N*8-1 -: 8]  = 8'h3C;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 5;
        if (a_byte !== 8'h00) begin miscompares++; $display("FAIL rst_byte_out got %h want 00", a_byte); end
        if (a_dc !== 1'b0)    begin miscompares++; $display("FAIL rst_byte_dc got %b want 0", a_dc); end
        if (a_valid !== 1'b0) begin miscompares++; $display("FAIL rst_byte_valid got %b want 0", a_valid); end
        if (a_busy !== 1'b0)  begin miscompares++; $display("FAIL rst_frame_busy got %b want 0", a_busy); end
        if (a_done !== 1'b0)  begin miscompares++; $display("FAIL rst_frame_done got %b want 0", a_done); end
        #1;
        base = acc_q.size();
        bd   = done_cnt;
        @(posedge clk); #1 rst_a = 1'b0;
        wait_done(bd + 1, 3000, ok);
        repeat (20) @(posedge clk);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL first_frame_timeout got no frame_done want one"); end
        vectors++;
        if (done_cnt - bd !== 1) begin miscompares++; $display("FAIL first_frame_done_count got %0d want 1", done_cnt - bd); end
        vectors++;
        if (acc_q.size() - base !== FLEN) begin
            miscompares++; $display("FAIL first_frame_len got %0d want %0d", acc_q.size() - base, FLEN);
        end else begin
            bad = -1;
            for (int k = 0; k < FLEN; k++) if (acc_q[base+k] !== exp_entry(img_a, k, 1'b0)) begin bad = k; break; end
            vectors++;
            if (bad >= 0) begin miscompares++; $display("FAIL first_frame_stream idx %0d got %h want %h", bad, acc_q[base+bad], exp_entry(img_a, bad, 1'b0)); end
            vectors += 2;
            if (acc_q[base+6] !== 9'h1A5) begin miscompares++; $display("FAIL first_data_byte got %h want 1a5", acc_q[base+6]); end
            if (acc_q[base+FLEN-1] !== 9'h13C) begin miscompares++; $display("FAIL last_data_byte got %h want 13c", acc_q[base+FLEN-1]); end
        end
        vectors++;
        if (done_cyc - latch_cyc + 1 !== 1032) begin
            miscompares++; $display("FAIL latch_to_done_cycles got %0d want 1032", done_cyc - latch_cyc + 1);
        end
    endtask

    task automatic test_estado_mid_frame();
        int base, bd, bad;
        bit ok;
        logic [N*8-1:0] img_old;
        for (int i = 0; i < N; i++) img_a[i*8 +: 8] = 8'(i);
        img_old = img_a;
        base = acc_q.size();
        bd   = done_cnt;
        pulse_rst_a();
        wait_size(base + 6 + 500, 3000, ok);
        est_a = 4'd2;
        img_a = ~img_old;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL estado_reach_byte500 got timeout want data byte 500"); end
        wait_done(bd + 2, 5000, ok);
        repeat (20) @(posedge clk);
        vectors++;
        if (done_cnt - bd !== 2) begin miscompares++; $display("FAIL estado_done_count got %0d want 2", done_cnt - bd); end
        vectors++;
        if (acc_q.size() - base !== 2 * FLEN) begin
            miscompares++; $display("FAIL estado_stream_len got %0d want %0d", acc_q.size() - base, 2 * FLEN);
        end else begin
            bad = -1;
            for (int k = 0; k < FLEN; k++) if (acc_q[base+k] !== exp_entry(img_old, k, 1'b0)) begin bad = k; break; end
            vectors++;
            if (bad >= 0) begin miscompares++; $display("FAIL estado_old_frame idx %0d got %h want %h", bad, acc_q[base+bad], exp_entry(img_old, bad, 1'b0)); end
            bad = -1;
            for (int k = 0; k < FLEN; k++) if (acc_q[base+FLEN+k] !== exp_entry(img_a, k, 1'b0)) begin bad = k; break; end
            vectors++;
            if (bad >= 0) begin miscompares++; $display("FAIL estado_new_frame idx %0d got %h want %h", bad, acc_q[base+FLEN+bad], exp_entry(img_a, bad, 1'b0)); end
        end
    endtask

    task automatic test_stall();
        int base, bd, be, bs, c0, bad;
        bit ok;
        base = acc_q.size();
        bd   = done_cnt;
        be   = stall_err;
        bs   = stall_cnt;
        c0   = cyc;
        est_a = 4'd0;
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk); #1;
            ready_a = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
            if (done_cnt >= bd + 1) begin ok = 1'b1; break; end
        end
        ready_a = 1'b1;
        repeat (20) @(posedge clk);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL stall_timeout got no frame_done want one"); end
        vectors++;
        if (latch_cyc - c0 !== 2) begin miscompares++; $display("FAIL estado_to_latch got %0d want 2", latch_cyc - c0); end
        vectors++;
        if (done_cnt - bd !== 1) begin miscompares++; $display("FAIL stall_done_count got %0d want 1", done_cnt - bd); end
        vectors++;
        if (stall_err - be !== 0) begin miscompares++; $display("FAIL stall_output_changed got %0d want 0", stall_err - be); end
        vectors++;
        if (stall_cnt - bs < 100) begin miscompares++; $display("FAIL stall_cycles_seen got %0d want >=100", stall_cnt - bs); end
        vectors++;
        if (acc_q.size() - base !== FLEN) begin
            miscompares++; $display("FAIL stall_stream_len got %0d want %0d", acc_q.size() - base, FLEN);
        end else begin
            bad = -1;
            for (int k = 0; k < FLEN; k++) if (acc_q[base+k] !== exp_entry(img_a, k, 1'b0)) begin bad = k; break; end
            vectors++;
            if (bad >= 0) begin miscompares++; $display("FAIL stall_stream idx %0d got %h want %h", bad, acc_q[base+bad], exp_entry(img_a, bad, 1'b0)); end
        end
    endtask

    task automatic test_reset_abort();
        int base, bd, bad;
        bit ok;
        bd = done_cnt;
        base = acc_q.size();
        pulse_rst_a();
        wait_size(base + 6 + 100, 3000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL abort_reach_byte100 got timeout want data byte 100"); end
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors += 5;
        if (a_byte !== 8'h00) begin miscompares++; $display("FAIL abort_byte_out got %h want 00", a_byte); end
        if (a_dc !== 1'b0)    begin miscompares++; $display("FAIL abort_byte_dc got %b want 0", a_dc); end
        if (a_valid !== 1'b0) begin miscompares++; $display("FAIL abort_byte_valid got %b want 0", a_valid); end
        if (a_busy !== 1'b0)  begin miscompares++; $display("FAIL abort_frame_busy got %b want 0", a_busy); end
        if (a_done !== 1'b0)  begin miscompares++; $display("FAIL abort_frame_done got %b want 0", a_done); end
        #1 rst_a = 1'b0;
        base = acc_q.size();
        wait_done(bd + 1, 3000, ok);
        repeat (20) @(posedge clk);
        vectors++;
        if (done_cnt - bd !== 1) begin miscompares++; $display("FAIL abort_done_count got %0d want 1", done_cnt - bd); end
        vectors++;
        if (acc_q.size() - base !== FLEN) begin
            miscompares++; $display("FAIL abort_restart_len got %0d want %0d", acc_q.size() - base, FLEN);
        end else begin
            vectors++;
            if (acc_q[base] !== 9'h021) begin miscompares++; $display("FAIL abort_restart_first got %h want 021", acc_q[base]); end
            bad = -1;
            for (int k = 0; k < FLEN; k++) if (acc_q[base+k] !== exp_entry(img_a, k, 1'b0)) begin bad = k; break; end
            vectors++;
            if (bad >= 0) begin miscompares++; $display("FAIL abort_restart_stream idx %0d got %h want %h", bad, acc_q[base+bad], exp_entry(img_a, bad, 1'b0)); end
        end
    endtask

`ifdef OLED_SCHED_BLINK_EN
    task automatic test_blink();
        int base, bd, bad;
        bit ok;
        for (int i = 0; i < N; i++) img_a[i*8 +: 8] = 8'h0F;
        est_a = 4'd4;
        base = acc_q.size();
        bd   = done_cnt;
        // After reset estado_q is 0, so the mismatch with 4 queues a second frame.
        pulse_rst_a();
        wait_done(bd + 2, 5000, ok);
        repeat (20) @(posedge clk);
        vectors++;
        if (done_cnt - bd !== 2) begin miscompares++; $display("FAIL blink_done_count got %0d want 2", done_cnt - bd); end
        vectors++;
        if (acc_q.size() - base !== 2 * FLEN) begin
            miscompares++; $display("FAIL blink_stream_len got %0d want %0d", acc_q.size() - base, 2 * FLEN);
        end else begin
            bad = -1;
            for (int k = 0; k < FLEN; k++) if (acc_q[base+k] !== exp_entry(img_a, k, 1'b0)) begin bad = k; break; end
            vectors++;
            if (bad >= 0) begin miscompares++; $display("FAIL blink_frame0 idx %0d got %h want %h", bad, acc_q[base+bad], exp_entry(img_a, bad, 1'b0)); end
            bad = -1;
            for (int k = 0; k < FLEN; k++) if (acc_q[base+FLEN+k] !== exp_entry(img_a, k, 1'b1)) begin bad = k; break; end
            vectors++;
            if (bad >= 0) begin miscompares++; $display("FAIL blink_frame1 idx %0d got %h want %h", bad, acc_q[base+FLEN+bad], exp_entry(img_a, bad, 1'b1)); end
        end
    endtask
`endif

    task automatic test_refresh();
        vectors++;
        if (b_start_q.size() < 3) begin
            miscompares++; $display("FAIL refresh_frame_count got %0d want >=3", b_start_q.size());
        end
        for (int i = 1; i < b_start_q.size(); i++) begin
            vectors++;
            if (b_start_q[i] - b_start_q[i-1] !== RC_B) begin
                miscompares++; $display("FAIL refresh_interval %0d got %0d want %0d", i, b_start_q[i] - b_start_q[i-1], RC_B);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) img_b[i*8 +: 8] = 8'(i ^ 8'h5A);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_estado_mid_frame();
        test_stall();
        test_reset_abort();
`ifdef OLED_SCHED_BLINK_EN
        test_blink();
`endif
        test_refresh();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/oled_frame_scheduler.md
Name: oled_frame_scheduler

Overview:
- Sequences transfer of the current 1024-byte Tamagotchi frame (`imagem`, from the image controller) to the OLED byte transmitter.
- Decides when a frame is sent: after reset, on any `estado` change, and on a periodic refresh.
- Emits a fixed addressing command preamble, then the 1024 data bytes, over a valid/ready byte handshake.
- Sits between the image controller and the SPI/I2C OLED transmitter.

Parameters:
- REFRESH_CYCLES, 2500000, clk cycles between periodic refresh requests (50 ms at 50 MHz); must be >= 2.
- N_BYTES, 1024, data bytes per frame; `imagem` width is N_BYTES*8.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- estado  input  4  current Tamagotchi state (IDLE=0, DORMINDO=1, COMENDO=2, DANDO_AULA=3, MORTO=4)
- imagem  input  N_BYTES*8  frame bitmap; byte i = imagem[i*8 +: 8]
- byte_out  output  8  byte to transmitter
- byte_dc  output  1  0 = command byte, 1 = data byte
- byte_valid  output  1  byte_out/byte_dc valid
- byte_ready  input  1  transmitter accepts the byte when byte_valid && byte_ready at a clk edge
- frame_busy  output  1  high from LATCH through DATA
- frame_done  output  1  one-cycle pulse after the last data byte is accepted

Behaviour:
- Reset values:
  - Outputs: byte_out=0, byte_dc=0, byte_valid=0, frame_busy=0, frame_done=0.
  - Internal: FSM=S_IDLE, estado_q=0, refresh counter=0, byte index=0.
  - pending=1, so the first frame is sent right after reset.
- Reset mid-frame aborts immediately. After the rst edge all outputs hold their reset values and no partial frame resumes.
- Trigger sources:
  - estado_q registers estado every cycle. If estado != estado_q at an edge, pending is set at that edge.
  - The refresh counter increments every cycle. At REFRESH_CYCLES-1 it wraps to 0 and sets pending.
  - The counter is also cleared on entry to S_LATCH.
- pending is cleared on entry to S_LATCH. A trigger in that same cycle wins and pending stays 1.
- Triggers during a transfer set pending. Exactly one additional frame follows, and multiple triggers coalesce.
- FSM states:
  - S_IDLE: if pending, go to S_LATCH.
  - S_LATCH (1 cycle): copy imagem into a shadow register so later changes to imagem cannot tear the frame. Go to S_CMD with index=0.
  - S_CMD: byte_dc=0. Sends 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07 in order. After the 6th byte is accepted, go to S_DATA with index=0.
  - S_DATA: byte_dc=1, byte_out = shadow byte[index], for index 0..N_BYTES-1. After byte N_BYTES-1 is accepted, go to S_DONE.
  - S_DONE (1 cycle): frame_done=1, then go to S_IDLE.
- Handshake rules:
  - byte_valid=1 throughout S_CMD/S_DATA. byte_out/byte_dc stay stable until accepted.
  - On acceptance the index advances; the next byte is presented on the following cycle with no bubble.
  - byte_ready low stalls indefinitely.
- Latency:
  - estado change at edge k: pending=1 after edge k, S_LATCH after k+1, first command byte valid after k+2.
  - With byte_ready held high, a frame is 1 + 6 + N_BYTES + 1 cycles from S_LATCH through S_DONE.
- frame_busy = (state is S_LATCH, S_CMD or S_DATA).

Optional Feature:
- Macro: OLED_SCHED_BLINK_EN.
- When defined:
  - A blink_phase bit (reset 0) toggles on every frame_done.
  - While the latched estado equals MORTO (4) and blink_phase=1, every data byte is sent bitwise-inverted.
  - Command bytes are never inverted.
  - The latched estado is captured in S_LATCH.
- When undefined: no blink_phase register; data bytes are sent unmodified.

Test Plan:
- Release rst with byte_ready=1 and imagem byte0=0xA5, byte1023=0x3C:
  - Stream is 0x21,0x00,0x7F,0x22,0x00,0x07 with dc=0.
  - Then 1024 bytes with dc=1; first byte 0xA5, last 0x3C.
  - frame_done pulses exactly once, 1032 cycles after S_LATCH entry.
- byte_ready toggled by random 30% stalls: the byte sequence is identical to the unstalled case, and byte_out never changes while byte_valid && !byte_ready.
- estado 0→2 during data byte 500, and imagem changed at the same time:
  - The current frame completes with the old image.
  - A second frame starts, carrying the new image.
  - Exactly two frame_done pulses occur.
- REFRESH_CYCLES=2000, estado constant, byte_ready=1: frames repeat, with consecutive first-command-byte acceptances exactly 2000 cycles apart.
- rst asserted at data byte 100 and released one cycle later:
  - Outputs are at reset values during rst.
  - A fresh frame restarts from command byte 0x21, with no frame_done for the aborted frame.
- With OLED_SCHED_BLINK_EN, estado=4 and imagem all 0x0F: data bytes alternate 0x0F / 0xF0 on successive frames, and command bytes are unchanged.
